// File: rtl/sam_ctrl_pkg.sv
// Shared definitions for the SAM microsequencer: state encoding, control-word
// bit positions, opcodes and the per-state control words driven onto b.
package sam_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST  = 5'd0,  S_F0 = 5'd1,  S_F1 = 5'd2,  S_FW = 5'd3,  S_F3 = 5'd4,
        S_F4   = 5'd5,  S_D0 = 5'd6,  S_M1 = 5'd7,  S_MW = 5'd8,  S_M3 = 5'd9,
        S_L4   = 5'd10, S_L5 = 5'd11, S_L6 = 5'd12, S_A4 = 5'd13, S_A5 = 5'd14,
        S_A6   = 5'd15, S_S1 = 5'd16, S_S2 = 5'd17, S_S3 = 5'd18, S_SW = 5'd19,
        S_B1   = 5'd20, S_HALT = 5'd21
    } state_e;

    localparam int B_ABUS_PC   = 21;
    localparam int B_ABUS_IR   = 20;
    localparam int B_ABUS_MBR  = 19;
    localparam int B_AC_RBUS   = 18;
    localparam int B_ALUA_AC   = 17;
    localparam int B_ALUB_MBUS = 16;
    localparam int B_ALU_ADD   = 15;
    localparam int B_ALU_PASSB = 14;
    localparam int B_ADDR_MAR  = 13;
    localparam int B_DATA_MBR  = 12;
    localparam int B_IR_ABUS   = 11;
    localparam int B_MAR_ABUS  = 10;
    localparam int B_MBR_DATA  = 9;
    localparam int B_MBR_RBUS  = 8;
    localparam int B_MBUS_MBR  = 7;
    localparam int B_PC_ZERO   = 6;
    localparam int B_PC_INC    = 5;
    localparam int B_PC_ABUS   = 4;
    localparam int B_RW        = 3;
    localparam int B_REQUEST   = 2;
    localparam int B_RBUS_AC   = 1;
    localparam int B_RBUS_ALU  = 0;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

    localparam logic [21:0] ONE = 22'd1;

    localparam logic [21:0] CW_RST  = ONE << B_PC_ZERO;
    localparam logic [21:0] CW_F0   = (ONE << B_ABUS_PC) | (ONE << B_MAR_ABUS);
    localparam logic [21:0] CW_RD   = (ONE << B_ADDR_MAR) | (ONE << B_RW) | (ONE << B_REQUEST);
    localparam logic [21:0] CW_F3   = (ONE << B_MBR_DATA) | (ONE << B_RW);
    localparam logic [21:0] CW_F4   = (ONE << B_ABUS_MBR) | (ONE << B_IR_ABUS) | (ONE << B_PC_INC);
    localparam logic [21:0] CW_D0   = (ONE << B_ABUS_IR) | (ONE << B_MAR_ABUS);
    localparam logic [21:0] CW_L4   = (ONE << B_ALUB_MBUS) | (ONE << B_ALU_PASSB) | (ONE << B_MBUS_MBR);
    localparam logic [21:0] CW_L5   = (ONE << B_ALU_PASSB) | (ONE << B_RBUS_ALU);
    localparam logic [21:0] CW_AC   = ONE << B_AC_RBUS;
    localparam logic [21:0] CW_A4   = (ONE << B_ALUA_AC) | (ONE << B_ALUB_MBUS) | (ONE << B_ALU_ADD)
                                    | (ONE << B_MBUS_MBR);
    localparam logic [21:0] CW_A5   = (ONE << B_ALU_ADD) | (ONE << B_RBUS_ALU);
    localparam logic [21:0] CW_S1   = ONE << B_RBUS_AC;
    localparam logic [21:0] CW_S2   = ONE << B_MBR_RBUS;
    localparam logic [21:0] CW_WR   = (ONE << B_ADDR_MAR) | (ONE << B_DATA_MBR) | (ONE << B_REQUEST);
    localparam logic [21:0] CW_B1   = (ONE << B_ABUS_IR) | (ONE << B_PC_ABUS);
    localparam logic [21:0] CW_HALT = 22'h000000;

    function automatic logic [21:0] cw_of(input state_e s);
        case (s)
            S_RST:                   cw_of = CW_RST;
            S_F0:                    cw_of = CW_F0;
            S_F1, S_FW, S_M1, S_MW:  cw_of = CW_RD;
            S_F3, S_M3:              cw_of = CW_F3;
            S_F4:                    cw_of = CW_F4;
            S_D0:                    cw_of = CW_D0;
            S_L4:                    cw_of = CW_L4;
            S_L5:                    cw_of = CW_L5;
            S_L6, S_A6:              cw_of = CW_AC;
            S_A4:                    cw_of = CW_A4;
            S_A5:                    cw_of = CW_A5;
            S_S1:                    cw_of = CW_S1;
            S_S2:                    cw_of = CW_S2;
            S_S3, S_SW:              cw_of = CW_WR;
            S_B1:                    cw_of = CW_B1;
            S_HALT:                  cw_of = CW_HALT;
            default:                 cw_of = CW_HALT;
        endcase
    endfunction

endpackage

// File: rtl/sam_wait_timer.sv
// Counts consecutive WAIT-high cycles of one memory access and flags the cycle
// on which the configured limit is reached.
module sam_wait_timer
    import sam_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64,
    parameter int TO_W         = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_r;

    // Wait-cycle counter, restarted at the start of every access
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // expired fires on the WAIT-high cycle that brings the count to the limit
    generate
        if (WAIT_TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = en && (cnt_r == TO_W'(WAIT_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/sam_microsequencer.sv
// SAM control unit: Moore sequencer issuing the 22-bit control word b through
// fetch, decode and execute, with a WAIT handshake on every memory access.
module sam_microsequencer
    import sam_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64,
    parameter int TO_W         = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WAIT,
    input  logic        ir15,
    input  logic        ir14,
    input  logic        ac15,
    output logic [21:0] b,
    output logic        bus_err
);

    state_e      state_r;
    state_e      next_s;
    logic [21:0] b_r;
    logic        bus_err_r;
    logic [1:0]  op_r;
    logic        in_wait_s;
    logic        clear_s;
    logic        expired_s;

    assign in_wait_s = (state_r == S_FW) || (state_r == S_MW) || (state_r == S_SW);
    assign clear_s   = (state_r == S_F1) || (state_r == S_M1) || (state_r == S_S3);

    sam_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .TO_W         (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .en      (in_wait_s && WAIT),
        .expired (expired_s)
    );

    // Next-state decode; wait states give WAIT=0 priority over a timeout
    always_comb begin
        next_s = S_RST;
        case (state_r)
            S_RST:  next_s = S_F0;
            S_F0:   next_s = S_F1;
            S_F1:   next_s = S_FW;
            S_FW:   next_s = !WAIT ? S_F3 : (expired_s ? S_HALT : S_FW);
            S_F3:   next_s = S_F4;
            S_F4:   next_s = S_D0;
            S_D0: begin
                case ({ir15, ir14})
                    OP_LOAD:  next_s = S_M1;
                    OP_ADD:   next_s = S_M1;
                    OP_STORE: next_s = S_S1;
                    OP_BRN:   next_s = ac15 ? S_B1 : S_F0;
                    default:  next_s = S_RST;
                endcase
            end
            S_M1:   next_s = S_MW;
            S_MW:   next_s = !WAIT ? S_M3 : (expired_s ? S_HALT : S_MW);
            S_M3:   next_s = (op_r == OP_ADD) ? S_A4 : S_L4;
            S_L4:   next_s = S_L5;
            S_L5:   next_s = S_L6;
            S_L6:   next_s = S_F0;
            S_A4:   next_s = S_A5;
            S_A5:   next_s = S_A6;
            S_A6:   next_s = S_F0;
            S_S1:   next_s = S_S2;
            S_S2:   next_s = S_S3;
            S_S3:   next_s = S_SW;
            S_SW:   next_s = !WAIT ? S_F0 : (expired_s ? S_HALT : S_SW);
            S_B1:   next_s = S_F0;
            S_HALT: next_s = S_HALT;
            default: next_s = S_RST;
        endcase
    end

    // State register; b is loaded with the word of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_RST;
            b_r       <= CW_RST;
            bus_err_r <= 1'b0;
            op_r      <= OP_LOAD;
        end else begin
            state_r   <= next_s;
            b_r       <= cw_of(next_s);
            bus_err_r <= bus_err_r | (next_s == S_HALT);
            op_r      <= (state_r == S_D0) ? {ir15, ir14} : op_r;
        end
    end

    assign b       = b_r;
    assign bus_err = bus_err_r;

endmodule

// File: tb/tb_sam_microsequencer.sv
// Randomized self-checking bench: builds the expected per-cycle control-word
// trace from the instruction tables and compares it against the DUT.
module tb_sam_microsequencer;

    localparam logic [21:0] W_RST  = 22'h000040;
    localparam logic [21:0] W_F0   = 22'h200400;
    localparam logic [21:0] W_RD   = 22'h00200C;
    localparam logic [21:0] W_MBR  = 22'h000208;
    localparam logic [21:0] W_F4   = 22'h080820;
    localparam logic [21:0] W_D0   = 22'h100400;
    localparam logic [21:0] W_L4   = 22'h014080;
    localparam logic [21:0] W_L5   = 22'h004001;
    localparam logic [21:0] W_AC   = 22'h040000;
    localparam logic [21:0] W_A4   = 22'h038080;
    localparam logic [21:0] W_A5   = 22'h008001;
    localparam logic [21:0] W_S1   = 22'h000002;
    localparam logic [21:0] W_S2   = 22'h000100;
    localparam logic [21:0] W_WR   = 22'h003004;
    localparam logic [21:0] W_B1   = 22'h100010;
    localparam int          TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        WAIT;
    logic        ir15;
    logic        ir14;
    logic        ac15;
    logic [21:0] b;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [21:0] b;
        logic        berr;
        logic        w;
        logic        rs;
        logic        fix;
        logic [1:0]  op;
        logic        ac;
    } step_t;

    step_t trace[$];

    sam_microsequencer #(.WAIT_TIMEOUT(TIMEOUT), .TO_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .WAIT    (WAIT),
        .ir15    (ir15),
        .ir14    (ir14),
        .ac15    (ac15),
        .b       (b),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void put(input logic [21:0] bw, input logic w, input logic berr);
        step_t s;
        s.b = bw; s.berr = berr; s.w = w; s.rs = 1'b0;
        s.fix = 1'b0; s.op = 2'b00; s.ac = 1'b0;
        trace.push_back(s);
    endfunction

    // request cycle, n busy cycles, then the cycle in which WAIT drops
    function automatic void access(input logic [21:0] bw, input int n);
        put(bw, rbit(), 1'b0);
        for (int i = 0; i < n; i++) put(bw, 1'b1, 1'b0);
        put(bw, 1'b0, 1'b0);
    endfunction

    function automatic void instr(input logic [1:0] op, input logic ac, input int nf, input int ne);
        put(W_F0, rbit(), 1'b0);
        access(W_RD, nf);
        put(W_MBR, rbit(), 1'b0);
        put(W_F4, rbit(), 1'b0);
        put(W_D0, rbit(), 1'b0);
        trace[trace.size()-1].fix = 1'b1;
        trace[trace.size()-1].op  = op;
        trace[trace.size()-1].ac  = ac;
        case (op)
            2'b00, 2'b10: begin
                put(W_RD, rbit(), 1'b0);
                for (int i = 0; i < ne; i++) put(W_RD, 1'b1, 1'b0);
                put(W_RD, 1'b0, 1'b0);
                put(W_MBR, rbit(), 1'b0);
                put((op == 2'b00) ? W_L4 : W_A4, rbit(), 1'b0);
                put((op == 2'b00) ? W_L5 : W_A5, rbit(), 1'b0);
                put(W_AC, rbit(), 1'b0);
            end
            2'b01: begin
                put(W_S1, rbit(), 1'b0);
                put(W_S2, rbit(), 1'b0);
                access(W_WR, ne);
            end
            default: begin
                if (ac) put(W_B1, rbit(), 1'b0);
            end
        endcase
    endfunction

    function automatic void reset_after_last();
        trace[trace.size()-1].rs = 1'b1;
        put(W_RST, rbit(), 1'b0);
    endfunction

    initial begin
        rst = 1'b1; WAIT = 1'b0; ir15 = 1'b0; ir14 = 1'b0; ac15 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_b", b, W_RST);
        check_val("reset_bus_err", bus_err, 0);
        rst = 1'b0;

        // directed: LOAD no wait, STORE with 4 busy cycles, BRN taken/not, ADD
        instr(2'b00, 1'b0, 0, 0);
        instr(2'b01, 1'b0, 0, 4);
        instr(2'b11, 1'b1, 0, 0);
        instr(2'b11, 1'b0, 0, 0);
        instr(2'b10, 1'b1, 1, 2);
        for (int i = 0; i < 40; i++)
            instr(2'($urandom_range(0, 3)), rbit(), $urandom_range(0, 5), $urandom_range(0, 5));

        // reset in the middle of an operand read
        put(W_F0, rbit(), 1'b0);
        access(W_RD, 0);
        put(W_MBR, 1'b0, 1'b0);
        put(W_F4, 1'b0, 1'b0);
        put(W_D0, 1'b0, 1'b0);
        trace[trace.size()-1].fix = 1'b1;
        put(W_RD, 1'b0, 1'b0);
        put(W_RD, 1'b1, 1'b0);
        put(W_RD, 1'b1, 1'b0);
        reset_after_last();
        instr(2'b00, 1'b0, 1, 1);

        // WAIT stuck high during fetch: TIMEOUT busy cycles, then HALT
        put(W_F0, rbit(), 1'b0);
        put(W_RD, rbit(), 1'b0);
        for (int i = 0; i < TIMEOUT; i++) put(W_RD, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) put(22'h000000, rbit(), 1'b1);
        reset_after_last();
        instr(2'b11, 1'b1, 0, 0);
        instr(2'b10, 1'b0, 3, 3);

        for (int k = 0; k < trace.size(); k++) begin
            @(negedge clk);
            check_val($sformatf("b@%0d", k), b, trace[k].b);
            check_val($sformatf("bus_err@%0d", k), bus_err, trace[k].berr);
            if (trace[k].b == W_RST)
                check_val($sformatf("request_low@%0d", k), b[2], 0);
            WAIT = trace[k].w;
            rst  = trace[k].rs;
            if (trace[k].fix) begin
                {ir15, ir14} = trace[k].op;
                ac15 = trace[k].ac;
            end else begin
                {ir15, ir14} = 2'($urandom_range(0, 3));
                ac15 = rbit();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sam_microsequencer.md
Name: sam_microsequencer

Overview:
Control unit for the SAM accumulator machine. It drives the 22-bit control word b into the datapath every cycle and sequences fetch, decode and execute. It completes a REQUEST/RW/WAIT handshake with memory on every memory access. It sits directly upstream of the datapath: it consumes IR[15], IR[14], AC[15] and WAIT, and produces b.

Parameters:
- WAIT_TIMEOUT, 64: maximum consecutive cycles WAIT may stay high in a wait state before a bus error is declared; 0 disables the timeout.
- TO_W, 7: width of the timeout counter; must satisfy 2^TO_W > WAIT_TIMEOUT.

Ports:
- clk  in  1  system clock; b updates on the rising edge; the datapath samples b on the falling edge.
- rst  in  1  reset, synchronous, active-high.
- WAIT  in  1  memory busy; data is valid / write is accepted once WAIT is low.
- ir15  in  1  IR[15], opcode MSB.
- ir14  in  1  IR[14], opcode LSB.
- ac15  in  1  AC[15], accumulator sign.
- b  out  22  registered control word (bit map below).
- bus_err  out  1  sticky WAIT-timeout flag.

Behaviour:
- b bit map: 21 ABUS=PC, 20 ABUS=IR, 19 ABUS=MBR, 18 AC=RBUS, 17 ALU_A=AC, 16 ALU_B=MBUS, 15 ALU add, 14 ALU pass-B, 13 ADDRESS_BUS=MAR, 12 DATA_BUS=MBR, 11 IR=ABUS, 10 MAR=ABUS, 9 MBR=DATA_BUS, 8 MBR=RBUS, 7 MBUS=MBR, 6 PC=0, 5 PC+=2, 4 PC=ABUS, 3 RW (1=read), 2 REQUEST, 1 RBUS=AC, 0 RBUS=ALU_RESULT.
- Output timing: Moore machine. b is registered and is a pure function of the current state.
- Reset: rst high at a posedge → state RST, b=22'h000040 (PC=0), bus_err=0, timeout counter=0. REQUEST is low during reset.
  - Reset mid-access abandons the access; REQUEST drops on that same edge.
  - Leaving RST: the first posedge with rst low moves to F0.
- Fetch sequence, with b value per state:
  - F0 0x200400
  - F1 0x00200C
  - FW 0x00200C; stays while WAIT=1
  - F3 0x000208
  - F4 0x080820
  - D0 0x100400 (MAR=IR)
  - F1 always moves to FW, so every access spends ≥1 cycle in FW.
- Dispatch on {ir15,ir14}, sampled at the posedge ending D0:
  - 00 LOAD: M1 0x00200C → MW 0x00200C (wait) → M3 0x000208 → L4 0x014080 → L5 0x004001 → L6 0x040000 → F0.
  - 10 ADD: M1 → MW → M3 as for LOAD → A4 0x038080 → A5 0x008001 → A6 0x040000 → F0.
  - 01 STORE: S1 0x000002 → S2 0x000100 → S3 0x003004 → SW 0x003004 (wait) → F0.
  - 11 BRN: if ac15=1, B1 0x100010 (PC=IR) → F0; else straight to F0.
  - Branch target is the full IR; memory decodes ADDRESS_BUS[13:0] only.
- Wait states: FW, MW and SW exit on the first posedge where WAIT=0.
  - The counter clears on entry to any wait state and increments each cycle WAIT=1.
  - If it reaches WAIT_TIMEOUT (nonzero), the next state is HALT: b=0, bus_err=1, held until rst.
- Zero-wait latency: fetch+decode 6 cycles; LOAD/ADD total 12; STORE 10; BRN 7 taken, 6 not taken.
- Illegal state encodings: next state RST.

Decomposition:
- Package sam_ctrl_pkg holds:
  - state enum
  - b bit-index constants (B_ABUS_PC=21 … B_RBUS_ALU=0)
  - opcode constants OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_BRN=2'b11
  - per-state control-word constants
- One sub-module, sam_wait_timer: timeout counter with clear/enable inputs and an expired output.

Test Plan:
- rst high 3 cycles, then low, WAIT=0 → b=0x000040 during reset; b sequence 0x200400, 0x00200C, 0x00200C, 0x000208, 0x080820, 0x100400.
- LOAD (ir=00), WAIT=0 → after D0: 0x00200C, 0x00200C, 0x000208, 0x014080, 0x004001, 0x040000, then 0x200400; 12 cycles total.
- STORE (ir=01), WAIT high 4 cycles in SW → 0x000002, 0x000100, then 0x003004 for 6 cycles, then 0x200400.
- BRN with ac15=1 → 0x100010 then 0x200400; with ac15=0 → 0x200400 directly after D0. ADD → A4 0x038080, A5 0x008001.
- WAIT_TIMEOUT=8, WAIT stuck high in FW → HALT after 8 wait cycles, b=0, bus_err=1; both held until rst.
- rst asserted while in MW → next b=0x000040, REQUEST low; restart fetch proceeds normally.
